serial_cmp_fsm: RTL

SERIAL_CMP_FSM -- requirements
Module: serial_cmp_fsm

---
 rtl/serial_cmp_fsm.sv | 133 +++++++++++++
 1 files changed

// File: rtl/serial_cmp_fsm.sv
// Bit-serial word comparator controller: consumes per-bit lt/gt/eq codes MSB first
// and reports the word result, stopping early at the first differing bit.
module serial_cmp_fsm #(
  parameter int WIDTH = 8
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_rst_n,
  input  logic                       i_w_start,
  input  logic                       i_w_bit_valid,
  input  logic                       i_w_bit_lt,
  input  logic                       i_w_bit_gt,
  input  logic                       i_w_bit_eq,
  output logic [$clog2(WIDTH)-1:0]   o_w_bit_idx,
  output logic                       o_w_busy,
  output logic                       o_w_done,
  output logic                       o_w_lt,
  output logic                       o_w_gt,
  output logic                       o_w_eq,
  output logic                       o_w_err
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             err_q, err_d;
  logic [2:0]       code;

  assign code = {i_w_bit_lt, i_w_bit_gt, i_w_bit_eq};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_w_start) begin
          state_d = ST_RUN;
          idx_d   = LAST_IDX;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Start requests are deliberately ignored here; only valid bits advance.
        if (i_w_bit_valid) begin
          unique case (code)
            3'b100: begin
              lt_d    = 1'b1;
              state_d = ST_DONE;
            end
            3'b010: begin
              gt_d    = 1'b1;
              state_d = ST_DONE;
            end
            3'b001: begin
              if (idx_q == '0) begin
                eq_d    = 1'b1;
                state_d = ST_DONE;
              end else begin
                idx_d = idx_q - IDX_W'(1);
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          endcase
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are derived from the next state so they are valid while in that state.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      err_q   <= err_d;
    end
  end

  assign o_w_bit_idx = idx_q;
  assign o_w_busy    = busy_q;
  assign o_w_done    = done_q;
  assign o_w_lt      = lt_q;
  assign o_w_gt      = gt_q;
  assign o_w_eq      = eq_q;
  assign o_w_err     = err_q;

endmodule
